// File: rtl/l2_pkg.sv
// Shared types and encodings for the L2 miss-control block.
// State enum, default counter width and datapath mux select values.
package l2_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TAG_CHECK  = 3'd1,
        HIT_ACCESS = 3'd2,
        EVICT      = 3'd3,
        FETCH      = 3'd4
    } l2_miss_state_t;

    localparam int L2_COUNT_WIDTH = 16;

    localparam logic ADDR_SEL_REQ    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;

    localparam logic WDATA_SEL_UPSTREAM = 1'b0;
    localparam logic WDATA_SEL_VC       = 1'b1;

endpackage

// File: rtl/l2_perf_counter.sv
// Wrapping event counter: +1 on the edge where inc is high, cleared asynchronously by rst_n.
// Count is visible one cycle after the inc cycle; no backpressure, wraps modulo 2^WIDTH.
module l2_perf_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/l2_vc_miss_control.sv
// L2 control FSM: hit servicing, dirty-LRU writeback and line fetch over the victim-cache port.
// Hit completes 2 cycles after the request; misses stall on l2_vc_resp with no timeout.
module l2_vc_miss_control
    import l2_pkg::*;
#(
    parameter int COUNT_WIDTH = L2_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    output logic                   mem_resp,
    input  logic                   hit,
    input  logic                   lru_valid,
    input  logic                   lru_dirty,
    output logic                   load_data,
    output logic                   load_tag,
    output logic                   set_dirty,
    output logic                   clear_dirty,
    output logic                   update_lru,
    output logic                   addr_sel,
    output logic                   wdata_sel,
    output logic                   l2_vc_read,
    output logic                   l2_vc_write,
    input  logic                   l2_vc_resp,
    output logic [COUNT_WIDTH-1:0] miss_count,
    output logic [COUNT_WIDTH-1:0] writeback_count
);

    l2_miss_state_t state;
    l2_miss_state_t state_next;
    logic           req;
    logic           miss_inc;
    logic           wb_inc;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_resp    = 1'b0;
        load_data   = 1'b0;
        load_tag    = 1'b0;
        set_dirty   = 1'b0;
        clear_dirty = 1'b0;
        update_lru  = 1'b0;
        addr_sel    = ADDR_SEL_REQ;
        wdata_sel   = WDATA_SEL_UPSTREAM;
        l2_vc_read  = 1'b0;
        l2_vc_write = 1'b0;
        miss_inc    = 1'b0;
        wb_inc      = 1'b0;

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = TAG_CHECK;
                end
            end

            // The post-fill re-check lands here too; it hits, so a miss is counted once.
            TAG_CHECK: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    state_next = HIT_ACCESS;
                end else if (lru_valid && lru_dirty) begin
                    state_next = EVICT;
                    miss_inc   = 1'b1;
                end else begin
                    state_next = FETCH;
                    miss_inc   = 1'b1;
                end
            end

            // A simultaneous read+write is serviced as a write.
            HIT_ACCESS: begin
                mem_resp   = 1'b1;
                update_lru = 1'b1;
                if (mem_write) begin
                    load_data = 1'b1;
                    set_dirty = 1'b1;
                    wdata_sel = WDATA_SEL_UPSTREAM;
                end
                state_next = IDLE;
            end

            EVICT: begin
                l2_vc_write = 1'b1;
                addr_sel    = ADDR_SEL_VICTIM;
                if (l2_vc_resp) begin
                    state_next = FETCH;
                    wb_inc     = 1'b1;
                end
            end

            // Fill strobes coincide with the response since read data is only valid that cycle.
            FETCH: begin
                l2_vc_read = 1'b1;
                addr_sel   = ADDR_SEL_REQ;
                if (l2_vc_resp) begin
                    load_data   = 1'b1;
                    load_tag    = 1'b1;
                    clear_dirty = 1'b1;
                    wdata_sel   = WDATA_SEL_VC;
                    state_next  = TAG_CHECK;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    l2_perf_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

    l2_perf_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_writeback_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb_inc),
        .count (writeback_count)
    );

    a_vc_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(l2_vc_read && l2_vc_write));

    a_vc_write_held: assert property (@(posedge clk) disable iff (!rst_n)
        (l2_vc_write && !l2_vc_resp) |=> l2_vc_write);

    a_vc_read_held: assert property (@(posedge clk) disable iff (!rst_n)
        (l2_vc_read && !l2_vc_resp) |=> l2_vc_read);

    a_resp_single: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp |=> !mem_resp);

endmodule

// File: tb/tb_l2_vc_miss_control.sv
// Bench for l2_vc_miss_control: transactions are described abstractly (hit/miss, op, evict and
// fetch lengths, optional drop) and expected per-cycle strobes are derived from that timeline.
module tb_l2_vc_miss_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0;
    logic          lru_valid = 1'b0, lru_dirty = 1'b0, l2_vc_resp = 1'b0;
    logic          mem_resp, load_data, load_tag, set_dirty, clear_dirty, update_lru;
    logic          addr_sel, wdata_sel, l2_vc_read, l2_vc_write;
    logic [CW-1:0] miss_count, writeback_count;

    int checks = 0;
    int passes = 0;
    int miss_exp = 0;
    int wb_exp = 0;

    always #5 clk = ~clk;

    l2_vc_miss_control #(.COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_resp        (mem_resp),
        .hit             (hit),
        .lru_valid       (lru_valid),
        .lru_dirty       (lru_dirty),
        .load_data       (load_data),
        .load_tag        (load_tag),
        .set_dirty       (set_dirty),
        .clear_dirty     (clear_dirty),
        .update_lru      (update_lru),
        .addr_sel        (addr_sel),
        .wdata_sel       (wdata_sel),
        .l2_vc_read      (l2_vc_read),
        .l2_vc_write     (l2_vc_write),
        .l2_vc_resp      (l2_vc_resp),
        .miss_count      (miss_count),
        .writeback_count (writeback_count)
    );

    // hitc: first tag check hits; m/n: evict/fetch lengths; drop_at: cycle the request goes low (-1 none)
    typedef struct {
        bit hitc;
        bit rd;
        bit wr;
        bit valid;
        bit dirty;
        int m;
        int n;
        int drop_at;
    } txn_t;

    // Bit order: 9 mem_resp, 8 load_data, 7 load_tag, 6 set_dirty, 5 clear_dirty,
    // 4 update_lru, 3 addr_sel, 2 wdata_sel, 1 l2_vc_read, 0 l2_vc_write
    function automatic logic [9:0] outs();
        return {mem_resp, load_data, load_tag, set_dirty, clear_dirty,
                update_lru, addr_sel, wdata_sel, l2_vc_read, l2_vc_write};
    endfunction

    function automatic txn_t mk(bit hitc, int op, bit valid, bit dirty, int m, int n);
        txn_t t;
        t.hitc = hitc;
        t.rd = (op != 1);
        t.wr = (op != 0);
        t.valid = valid;
        t.dirty = dirty;
        t.m = m;
        t.n = n;
        t.drop_at = -1;
        return t;
    endfunction

    function automatic int evict_len(txn_t t);
        return (!t.hitc && t.valid && t.dirty) ? t.m : 0;
    endfunction

    function automatic int fetch_start(txn_t t);
        return 2 + evict_len(t);
    endfunction

    function automatic int acc_cycle(txn_t t);
        return t.hitc ? 2 : fetch_start(t) + t.n + 1;
    endfunction

    function automatic int txn_len(txn_t t);
        return (t.drop_at >= 0) ? fetch_start(t) + t.n + 2 : acc_cycle(t) + 1;
    endfunction

    function automatic logic [9:0] exp_vec(txn_t t, int c);
        logic [9:0] v;
        int fs;
        v = '0;
        fs = fetch_start(t);
        if (!t.hitc) begin
            if (c >= 2 && c < fs) begin
                v[0] = 1'b1;
                v[3] = 1'b1;
            end
            if (c >= fs && c < fs + t.n) v[1] = 1'b1;
            if (c == fs + t.n - 1) begin
                v[8] = 1'b1;
                v[7] = 1'b1;
                v[5] = 1'b1;
                v[2] = 1'b1;
            end
        end
        if (c == acc_cycle(t) && t.drop_at < 0) begin
            v[9] = 1'b1;
            v[4] = 1'b1;
            if (t.wr) begin
                v[8] = 1'b1;
                v[6] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic void commit(txn_t t);
        if (!t.hitc) miss_exp++;
        if (evict_len(t) > 0) wb_exp++;
    endfunction

    // Drives cycle c of transaction t; inputs the FSM must ignore that cycle get random values.
    task automatic drive_cycle(input txn_t t, input int c, output logic [9:0] o,
                               output logic [CW-1:0] mc, output logic [CW-1:0] wc);
        int  ev, fs, acc;
        bit  req_on, window;
        ev = evict_len(t);
        fs = fetch_start(t);
        acc = acc_cycle(t);
        @(posedge clk);
        #1;
        req_on = (c <= acc) && (t.drop_at < 0 || c < t.drop_at);
        mem_read = req_on && t.rd;
        mem_write = req_on && t.wr;
        hit = (c == 1) ? t.hitc : ((c == acc - 1) ? 1'b1 : 1'($urandom));
        lru_valid = (c == 1) ? t.valid : 1'($urandom);
        lru_dirty = (c == 1) ? t.dirty : 1'($urandom);
        window = !t.hitc && c >= 2 && c < fs + t.n;
        l2_vc_resp = window ? ((ev > 0 && c == 1 + ev) || c == fs + t.n - 1) : 1'($urandom);
        @(negedge clk);
        o = outs();
        mc = miss_count;
        wc = writeback_count;
    endtask

    task automatic idle_inputs();
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        hit = 1'b0;
        lru_valid = 1'b0;
        lru_dirty = 1'b0;
        l2_vc_resp = 1'b0;
    endtask

    task automatic test_reset();
        mem_read = 1'b1;
        hit = 1'b1;
        l2_vc_resp = 1'b1;
        #12;
        checks++;
        if (outs() !== 10'b0) $display("FAIL reset_outputs got %b want %b", outs(), 10'b0);
        else passes++;
        checks++;
        if (miss_count !== '0 || writeback_count !== '0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", miss_count, writeback_count);
        else passes++;
        mem_read = 1'b0;
        hit = 1'b0;
        l2_vc_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_hit();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        int resp_at, resp_n;
        t = mk(1'b1, 0, 1'b0, 1'b0, 0, 0);
        resp_at = -1;
        resp_n = 0;
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            if (o[9]) begin resp_at = c; resp_n++; end
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL read_hit c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (resp_at != 2 || resp_n != 1) $display("FAIL read_hit_latency got cycle %0d x%0d want cycle 2 x1", resp_at, resp_n);
        else passes++;
        checks++;
        if (mc !== CW'(miss_exp)) $display("FAIL read_hit_miss_count got %0d want %0d", mc, CW'(miss_exp));
        else passes++;
    endtask

    task automatic test_write_hit();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        t = mk(1'b1, 1, 1'b1, 1'b1, 0, 0);
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL write_hit c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (o !== 10'b1101010000) $display("FAIL write_hit_strobes got %b want %b", o, 10'b1101010000);
        else passes++;
    endtask

    task automatic test_clean_miss();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        int rd_n, resp_at;
        t = mk(1'b0, 0, 1'b1, 1'b0, 0, 5);
        rd_n = 0;
        resp_at = -1;
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            if (o[1]) rd_n++;
            if (o[9]) resp_at = c;
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL clean_miss c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (rd_n != 5 || resp_at != 8) $display("FAIL clean_miss_timing got read %0d resp %0d want 5 and 8", rd_n, resp_at);
        else passes++;
        checks++;
        if (mc !== CW'(miss_exp)) $display("FAIL clean_miss_count got %0d want %0d", mc, CW'(miss_exp));
        else passes++;
    endtask

    task automatic test_dirty_miss();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        int wr_n, rd_n, both_n;
        t = mk(1'b0, 0, 1'b1, 1'b1, 3, 4);
        wr_n = 0;
        rd_n = 0;
        both_n = 0;
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            if (o[0] && o[3]) wr_n++;
            if (o[1]) rd_n++;
            if (o[0] && o[1]) both_n++;
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL dirty_miss c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (wr_n != 3 || rd_n != 4 || both_n != 0)
            $display("FAIL dirty_miss_handshake got wr %0d rd %0d both %0d want 3 4 0", wr_n, rd_n, both_n);
        else passes++;
        checks++;
        if (mc !== CW'(miss_exp) || wc !== CW'(wb_exp))
            $display("FAIL dirty_miss_counts got %0d/%0d want %0d/%0d", mc, wc, CW'(miss_exp), CW'(wb_exp));
        else passes++;
    endtask

    task automatic test_drop();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        int resp_n;
        t = mk(1'b0, 0, 1'b1, 1'b1, 2, 4);
        t.drop_at = 3;
        resp_n = 0;
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            if (o[9]) resp_n++;
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL drop c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (resp_n != 0 || mc !== CW'(miss_exp) || wc !== CW'(wb_exp))
            $display("FAIL drop_result got resp %0d counts %0d/%0d want 0 %0d/%0d", resp_n, mc, wc, CW'(miss_exp), CW'(wb_exp));
        else passes++;
    endtask

    task automatic test_random();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        for (int i = 0; i < 60; i++) begin
            t = mk(($urandom % 3) == 0, int'($urandom % 3), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            if (!t.hitc && ($urandom % 5) == 0)
                t.drop_at = int'($urandom_range(2, fetch_start(t) + t.n - 1));
            for (int c = 0; c < txn_len(t); c++) begin
                drive_cycle(t, c, o, mc, wc);
                checks++;
                if (o !== exp_vec(t, c)) $display("FAIL random t%0d c%0d got %b want %b", i, c, o, exp_vec(t, c));
                else passes++;
            end
            commit(t);
            checks++;
            if (mc !== CW'(miss_exp) || wc !== CW'(wb_exp))
                $display("FAIL random_counts t%0d got %0d/%0d want %0d/%0d", i, mc, wc, CW'(miss_exp), CW'(wb_exp));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        miss_exp = 0;
        wb_exp = 0;
        for (int i = 0; i < 16; i++) begin
            t = mk(1'b0, int'($urandom % 3), 1'b0, 1'($urandom), 0, int'($urandom_range(1, 3)));
            for (int c = 0; c < txn_len(t); c++) begin
                drive_cycle(t, c, o, mc, wc);
                checks++;
                if (o !== exp_vec(t, c)) $display("FAIL wrap t%0d c%0d got %b want %b", i, c, o, exp_vec(t, c));
                else passes++;
            end
            commit(t);
            checks++;
            if (mc !== CW'(miss_exp)) $display("FAIL wrap_count t%0d got %0d want %0d", i, mc, CW'(miss_exp));
            else passes++;
        end
        checks++;
        if (mc !== '0 || wc !== '0) $display("FAIL wrap_to_zero got %0d/%0d want 0/0", mc, wc);
        else passes++;
    endtask

    task automatic test_reset_mid_fetch();
        txn_t t;
        logic [9:0] o;
        logic [CW-1:0] mc, wc;
        t = mk(1'b0, 0, 1'b0, 1'b0, 0, 6);
        for (int c = 0; c < 4; c++) begin
            drive_cycle(t, c, o, mc, wc);
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL rst_fetch c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 10'b0 || miss_count !== '0 || writeback_count !== '0)
            $display("FAIL rst_fetch_async got %b %0d/%0d want all 0", outs(), miss_count, writeback_count);
        else passes++;
        mem_read = 1'b0;
        l2_vc_resp = 1'b0;
        miss_exp = 0;
        wb_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        t = mk(1'b1, 0, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < txn_len(t); c++) begin
            drive_cycle(t, c, o, mc, wc);
            checks++;
            if (o !== exp_vec(t, c)) $display("FAIL rst_fetch_hit c%0d got %b want %b", c, o, exp_vec(t, c));
            else passes++;
        end
        commit(t);
        checks++;
        if (mc !== '0 || wc !== '0) $display("FAIL rst_fetch_counts got %0d/%0d want 0/0", mc, wc);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_drop();
        test_random();
        test_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/l2_vc_miss_control.md
# l2_vc_miss_control

L2 cache control FSM on the initiator side of the L2↔victim-cache request port.
- Services read/write requests from the L1 side and reports each L2 hit.
- On a miss it writes back a dirty LRU line to the victim cache, fetches the missing line from the victim cache, fills the way, and re-checks.
- Drives only control signals into the L2 datapath. Tag compare, data arrays and LRU storage live in the datapath.

## Interface
Parameters:
- COUNT_WIDTH, 16, width of the performance counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  upstream read request, held until mem_resp
- mem_write  in  1  upstream write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- hit  in  1  datapath tag-match for the current address
- lru_valid  in  1  LRU way of the indexed set is valid
- lru_dirty  in  1  LRU way of the indexed set is dirty
- load_data  out  1  write the selected data into the line
- load_tag  out  1  write tag and set the valid bit of the LRU way
- set_dirty  out  1  set the dirty bit of the accessed way
- clear_dirty  out  1  clear the dirty bit of the filled way
- update_lru  out  1  mark the accessed way most-recently-used
- addr_sel  out  1  0 = request address, 1 = victim (LRU tag) address to the victim cache
- wdata_sel  out  1  0 = upstream write data, 1 = victim-cache read data into the array
- l2_vc_read  out  1  read request to the victim cache
- l2_vc_write  out  1  write(-back) request to the victim cache
- l2_vc_resp  in  1  victim cache completion
- miss_count  out  COUNT_WIDTH  misses since reset
- writeback_count  out  COUNT_WIDTH  completed writebacks since reset

## Operation
State machine states: IDLE, TAG_CHECK, HIT_ACCESS, EVICT, FETCH.

Outputs are combinational from state and inputs. All outputs are 0 unless asserted below.

- IDLE: leave on (mem_read | mem_write) to TAG_CHECK.
- TAG_CHECK:
  - if the request has dropped → IDLE;
  - hit → HIT_ACCESS;
  - miss & lru_valid & lru_dirty → EVICT;
  - other miss → FETCH.
- HIT_ACCESS:
  - mem_resp=1 and update_lru=1;
  - if mem_write, also load_data=1 and set_dirty=1 (wdata_sel=0);
  - → IDLE.
- EVICT:
  - l2_vc_write=1, addr_sel=1;
  - on l2_vc_resp → FETCH and increment writeback_count.
- FETCH:
  - l2_vc_read=1, addr_sel=0;
  - on l2_vc_resp, in the same cycle assert load_data, load_tag and clear_dirty with wdata_sel=1;
  - → TAG_CHECK. The re-check then hits.
- miss_count increments on every TAG_CHECK→EVICT or TAG_CHECK→FETCH transition.
  - Each miss counts once, because the re-check after a fill hits.
- Both counters wrap modulo 2^COUNT_WIDTH and never saturate.
- mem_read and mem_write asserted together is illegal; the block treats it as a write.

## Timing
- Reset: asserting rst_n low forces state to IDLE and both counters to 0 immediately, without waiting for a clock edge.
  - All outputs read 0 while in reset and in IDLE.
  - Reset mid-EVICT/FETCH drops the request with no completion.
- Hit latency: request sampled in IDLE at edge 0, TAG_CHECK in cycle 1, mem_resp in cycle 2.
  - The next request is accepted from cycle 3.
- Clean miss: TAG_CHECK, then FETCH for N cycles until l2_vc_resp, then TAG_CHECK, then HIT_ACCESS. mem_resp arrives N+3 cycles after the request.
- Dirty miss: adds EVICT for M cycles before FETCH.
- Victim-cache handshake:
  - l2_vc_read/l2_vc_write are held constant until l2_vc_resp is sampled high, and deassert the next cycle.
  - Never both high. Never asserted outside EVICT/FETCH.
  - l2_vc_resp in the same cycle as a request's first assertion is legal; the victim cache may respond combinationally from its memory response.
- l2_vc_resp outside EVICT/FETCH is ignored.
- Upstream dropping its request during EVICT/FETCH does not abort the downstream transaction. The drop is seen at the next TAG_CHECK, which returns to IDLE without mem_resp.
- mem_resp is exactly one cycle per completed request.

## Structure
- l2_pkg: state enum type (l2_miss_state_t), default COUNT_WIDTH, addr_sel/wdata_sel encoding constants.
- Sub-module l2_perf_counter:
  - parameterised wrapping counter with async active-low clear and inc enable;
  - instantiated twice (miss_count, writeback_count).

## Test plan
- Read hit: mem_read=1, hit=1 → mem_resp high in cycle 2 only; update_lru=1 that cycle; miss_count=0.
- Write hit: mem_write=1, hit=1 → cycle 2 has load_data=1, set_dirty=1, wdata_sel=0, mem_resp=1.
- Clean read miss: hit=0 and lru_dirty=0, then hit=1 after the fill; l2_vc_resp after 5 cycles.
  - l2_vc_read high exactly 5 cycles; fill strobes with wdata_sel=1 on the resp cycle.
  - mem_resp 8 cycles after the request; miss_count=1.
- Dirty miss: lru_valid=1, lru_dirty=1; writeback resp after 3 cycles, fetch resp after 4 cycles.
  - l2_vc_write high 3 cycles with addr_sel=1, then l2_vc_read high 4 cycles.
  - writeback_count=1, miss_count=1, never both requests high.
- Wrap: preload via 65536 misses (or COUNT_WIDTH=4 with 16 misses) → miss_count returns to 0 and no other output is disturbed.
- Reset mid-FETCH: drive rst_n=0 while l2_vc_read=1 → l2_vc_read drops with no clock edge; counters=0; after release, a hit completes with the normal 2-cycle latency.
